// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one m_uart_tx between N_REQ byte streams.
// An owner keeps the UART until its last byte, or until it idles LOCK_TMO cycles.
module uart_tx_arbiter #(
   parameter int N_REQ    = 4,
   parameter int LOCK_TMO = 1024
) (
   input  logic               w_clk,
   input  logic               w_rst_n,
   input  logic [N_REQ-1:0]   w_req_valid,
   input  logic [8*N_REQ-1:0] w_req_data,
   input  logic [N_REQ-1:0]   w_req_last,
   output logic [N_REQ-1:0]   r_req_ack,
   output logic               r_tx_we,
   output logic [7:0]         r_tx_data,
   input  logic               w_tx_ready,
   output logic [N_REQ-1:0]   r_grant,
   output logic               r_busy
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(LOCK_TMO);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

   state_t           state, state_nx;
   logic             locked, locked_nx;
   logic [PW-1:0]    owner, owner_nx;
   logic [PW-1:0]    ptr, ptr_nx;
   logic [CW-1:0]    tmo, tmo_nx;
   logic             we_nx;
   logic [7:0]       data_nx;
   logic [N_REQ-1:0] ack_nx, grant_nx;

   logic [N_REQ-1:0] eligible;
   logic             found;
   logic [PW-1:0]    win;

   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int b);
      int s;
      s = int'(a) + b;
      if (s >= N_REQ) s = s - N_REQ;
      return PW'(s);
   endfunction

   function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] i);
      logic [N_REQ-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Winner is the first eligible index at or after the pointer.
   always_comb begin
      eligible = locked ? (w_req_valid & onehot(owner)) : w_req_valid;
      found    = 1'b0;
      win      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && eligible[wrap_add(ptr, k)]) begin
            found = 1'b1;
            win   = wrap_add(ptr, k);
         end
      end
   end

   always_comb begin
      state_nx  = state;
      locked_nx = locked;
      owner_nx  = owner;
      ptr_nx    = ptr;
      tmo_nx    = '0;
      we_nx     = 1'b0;
      data_nx   = r_tx_data;
      ack_nx    = '0;
      grant_nx  = r_grant;
      case (state)
         IDLE: begin
            if (w_tx_ready) begin
               // Expiry beats an owner byte arriving in the same cycle.
               if (locked && tmo == CW'(LOCK_TMO - 1)) begin
                  locked_nx = 1'b0;
                  grant_nx  = '0;
                  ptr_nx    = wrap_add(owner, 1);
               end else if (found) begin
                  state_nx = ISSUE;
                  we_nx    = 1'b1;
                  data_nx  = w_req_data[8*win +: 8];
                  ack_nx   = onehot(win);
                  grant_nx = onehot(win);
                  owner_nx = win;
                  if (w_req_last[win]) begin
                     locked_nx = 1'b0;
                     ptr_nx    = wrap_add(win, 1);
                  end else begin
                     locked_nx = 1'b1;
                  end
               end else if (locked) begin
                  tmo_nx = tmo + 1'b1;
               end
            end
         end
         ISSUE:     state_nx = WAIT_BUSY;
         WAIT_BUSY: if (!w_tx_ready) state_nx = WAIT_DONE;
         WAIT_DONE: begin
            if (w_tx_ready) begin
               state_nx = IDLE;
               if (!locked) grant_nx = '0;
            end
         end
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge w_clk) begin
      if (!w_rst_n) begin
         state     <= IDLE;
         locked    <= 1'b0;
         owner     <= '0;
         ptr       <= '0;
         tmo       <= '0;
         r_tx_we   <= 1'b0;
         r_tx_data <= '0;
         r_req_ack <= '0;
         r_grant   <= '0;
      end else begin
         state     <= state_nx;
         locked    <= locked_nx;
         owner     <= owner_nx;
         ptr       <= ptr_nx;
         tmo       <= tmo_nx;
         r_tx_we   <= we_nx;
         r_tx_data <= data_nx;
         r_req_ack <= ack_nx;
         r_grant   <= grant_nx;
      end
   end

   assign r_busy = (state != IDLE) || locked;

endmodule
